zone_alarm_decoder: RTL
=======================

# zone_alarm_decoder

Consumer at the far end of the three-zone buzzer interface: samples the one-hot buzzer lines, validates each alarm pulse (one-hot, expected width), and turns it into a queued event record. Events are read out through a valid/ready handshake, and per-zone good-pulse counters are kept. The block sits downstream of the zone alarm controller, on the same clock, and feeds the logging/readout logic.

## Interface
- `PULSE_LEN`, 31: nominal buzzer-high length in cycles.
- `TOL`, 2: accepted deviation; good pulse width is in [PULSE_LEN-TOL, PULSE_LEN+TOL].
- `CNT_W`, 8: per-zone counter width.
- `FIFO_DEPTH`, 4: event queue entries; must be a power of two, ≥2.
- `clk` in 1: single clock; all logic rises on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `ena` in 1: global enable; low freezes every register, including the FIFO, and `evt_ready_i` is ignored.
- `buzz_i` in 3: buzzer lines, zone1..zone3 on bits 0..2; synchronous to `clk`, no synchronizer.
- `evt_valid_o` out 1: FIFO head valid.
- `evt_ready_i` in 1: consumer accepts the head; a pop occurs when valid && ready && ena.
- `evt_zone_o` out 2: head zone (1..3; 0 = undecodable).
- `evt_code_o` out 2: head code; 00 OK, 01 SHORT, 10 LONG, 11 GLITCH.
- `cnt_sel_i` in 2: counter select (1..3; 0 reads zero).
- `cnt_o` out CNT_W: selected zone's OK count (combinational mux of registers).
- `overflow_o` out 1: sticky; an event was dropped because the FIFO was full.

## Operation
- Reset values: FSM = IDLE, width = 0, zone latch = 0, FIFO empty, `evt_valid_o` 0, `evt_zone_o`/`evt_code_o` 0, counters 0, `cnt_o` 0, `overflow_o` 0.
- FSM states and transitions (all gated by `ena`):
  - IDLE, `buzz_i`==0: stay.
  - IDLE, `buzz_i` one-hot: latch zone, width←1, go to MEASURE.
  - IDLE, `buzz_i` multi-hot: push {0, GLITCH}, go to WAIT_LOW.
  - MEASURE, `buzz_i` == latched pattern: width←width+1. When the incremented width would exceed PULSE_LEN+TOL, push {zone, LONG} and go to WAIT_LOW.
  - MEASURE, `buzz_i`==0: push {zone, OK} if width is in range, else {zone, SHORT}; go to IDLE.
  - MEASURE, `buzz_i` nonzero and different from the latched pattern: push {zone, GLITCH}, go to WAIT_LOW.
  - WAIT_LOW: stay until `buzz_i`==0, then go to IDLE. No further events in this state.
- Width counter is $clog2(PULSE_LEN+TOL+2) bits and never wraps.
- An OK push increments that zone's counter, saturating at all-ones. The counter updates even if the FIFO push is dropped.
- Push while the FIFO is full: the record is discarded and `overflow_o`←1 (cleared only by `rst`). If a pop occurs in the same cycle, the push is accepted and there is no overflow.
- Push and pop in the same cycle on a non-empty, non-full FIFO: occupancy is unchanged.
- `rst` mid-pulse: the state is cleared. If `buzz_i` is still high after release, it is treated as a new pulse start and measured from 1, so it normally yields SHORT.

## Timing
- Width is counted in sampled high cycles: a pulse sampled high on N consecutive edges has width N.
- Event latency: the edge that samples the terminating condition writes the FIFO. `evt_valid_o` is high starting the next cycle (one cycle after the low or glitch sample).
- FIFO is show-ahead: head fields are valid whenever `evt_valid_o`=1 and are stable until popped.
- A pop at edge t exposes the next entry after t. Back-to-back pops at full rate are allowed.
- `cnt_o` reflects a counter increment one cycle after the push edge.

## Structure
- Shared package `alarm_pkg`:
  - `evt_code_t` (OK/SHORT/LONG/GLITCH) and `fsm_state_t` (IDLE/MEASURE/WAIT_LOW).
  - Event record typedef {zone[1:0], code[1:0]}.
  - Zone encodings 1..3.
  - The nominal PULSE_LEN constant, shared with the alarm controller.
- One sub-module, `alarm_evt_fifo`: parameterized sync FIFO (width 4, depth FIFO_DEPTH) with show-ahead output, full/empty flags and an `ena` gate. The FSM and counters live in the top.

## Test plan
- Zone 2 high (3'b010) for 31 cycles, then 0; ready=1 → one event {2, OK} with valid one cycle after the low sample; cnt_sel=2 gives `cnt_o`=1.
- Zone 1 high for 10 cycles → {1, SHORT}. Zone 3 held high for 40 cycles → {3, LONG} emitted after sample 34 (width 33 → 34), nothing further until low.
- 3'b001 for 5 cycles, then 3'b100 → {1, GLITCH}, then WAIT_LOW until 0. Separately, 3'b011 from IDLE → {0, GLITCH}.
- ready=0, five OK pulses → 4 queued, `overflow_o`=1, zone counter=5. Then ready=1 → four pops in order on consecutive cycles and valid drops.
- `ena`=0 for 8 cycles mid-pulse (width frozen, input ignored), then resume with a total of 31 enabled high samples → OK. Assert `rst` asynchronously mid-pulse → outputs go to zero immediately, with no clock edge needed.

Source files
------------

// File: rtl/alarm_pkg.sv
`default_nettype none
// ---- alarm_pkg : types and helpers shared by the zone alarm blocks ---- rev 1.0 ----

package alarm_pkg;

  // Nominal buzzer-high length, shared with the upstream alarm controller.
  localparam int PULSE_LEN = 31;

  typedef enum logic [1:0] {
    EVT_OK     = 2'b00,
    EVT_SHORT  = 2'b01,
    EVT_LONG   = 2'b10,
    EVT_GLITCH = 2'b11
  } evt_code_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEASURE  = 2'd1,
    ST_WAIT_LOW = 2'd2
  } fsm_state_t;

  typedef logic [1:0] zone_t;

  localparam zone_t ZONE_NONE = 2'd0;
  localparam zone_t ZONE_1    = 2'd1;
  localparam zone_t ZONE_2    = 2'd2;
  localparam zone_t ZONE_3    = 2'd3;

  typedef struct packed {
    zone_t     zone;
    evt_code_t code;
  } evt_rec_t;

  localparam int EVT_W = $bits(evt_rec_t);

  function automatic logic is_onehot3(input logic [2:0] v);
    return (v != 3'd0) && ((v & (v - 3'd1)) == 3'd0);
  endfunction

  function automatic zone_t onehot_to_zone(input logic [2:0] v);
    case (v)
      3'b001:  return ZONE_1;
      3'b010:  return ZONE_2;
      3'b100:  return ZONE_3;
      default: return ZONE_NONE;
    endcase
  endfunction

  function automatic logic [2:0] zone_to_onehot(input zone_t z);
    case (z)
      ZONE_1:  return 3'b001;
      ZONE_2:  return 3'b010;
      ZONE_3:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/alarm_evt_fifo.sv
`default_nettype none
// ---- alarm_evt_fifo : show-ahead sync FIFO with enable gate ---- rev 1.0 ----

module alarm_evt_fifo
  import alarm_pkg::*;
#(
  parameter int WIDTH = EVT_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = ena && pop && !empty;
  assign do_push = ena && push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Head reads as zero while empty so stale entries never leak out.
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/zone_alarm_decoder.sv
`default_nettype none
// ---- zone_alarm_decoder : validates one-hot buzzer pulses into queued events ---- rev 1.0 ----

module zone_alarm_decoder
  import alarm_pkg::*;
#(
  parameter int PULSE_LEN  = alarm_pkg::PULSE_LEN,
  parameter int TOL        = 2,
  parameter int CNT_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [2:0]       buzz_i,
  output logic             evt_valid_o,
  input  logic             evt_ready_i,
  output logic [1:0]       evt_zone_o,
  output logic [1:0]       evt_code_o,
  input  logic [1:0]       cnt_sel_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             overflow_o
);

  localparam int MAX_LEN = PULSE_LEN + TOL;
  localparam int MIN_LEN = PULSE_LEN - TOL;
  localparam int WID_W   = $clog2(MAX_LEN + 2);
  localparam logic [WID_W-1:0] WID_MAX = WID_W'(MAX_LEN);
  localparam logic [WID_W-1:0] WID_MIN = WID_W'(MIN_LEN);

  fsm_state_t       state;
  logic [WID_W-1:0] width;
  zone_t            zone;
  logic [CNT_W-1:0] cnt [3];
  logic             overflow;

  logic [WID_W-1:0] width_inc;
  logic [2:0]       zone_pat;
  logic             push;
  evt_rec_t         push_rec;
  logic             ok_push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [EVT_W-1:0] head_bits;
  evt_rec_t         head;

  // Width is at most MAX_LEN while measuring, so the increment cannot wrap.
  assign width_inc = width + 1'b1;
  assign zone_pat  = zone_to_onehot(zone);

  always_comb begin
    push     = 1'b0;
    push_rec = '{zone: ZONE_NONE, code: EVT_OK};
    unique case (state)
      ST_IDLE: begin
        if (buzz_i != 3'd0 && !is_onehot3(buzz_i)) begin
          push     = 1'b1;
          push_rec = '{zone: ZONE_NONE, code: EVT_GLITCH};
        end
      end
      ST_MEASURE: begin
        if (buzz_i == zone_pat) begin
          if (width_inc > WID_MAX) begin
            push     = 1'b1;
            push_rec = '{zone: zone, code: EVT_LONG};
          end
        end else if (buzz_i == 3'd0) begin
          push     = 1'b1;
          push_rec = '{zone: zone,
                       code: (width >= WID_MIN && width <= WID_MAX) ? EVT_OK : EVT_SHORT};
        end else begin
          push     = 1'b1;
          push_rec = '{zone: zone, code: EVT_GLITCH};
        end
      end
      default: ;
    endcase
    if (!ena) push = 1'b0;
  end

  assign ok_push = push && (push_rec.code == EVT_OK);
  assign pop     = evt_valid_o && evt_ready_i && ena;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      width <= '0;
      zone  <= ZONE_NONE;
    end else if (ena) begin
      unique case (state)
        ST_IDLE: begin
          if (is_onehot3(buzz_i)) begin
            zone  <= onehot_to_zone(buzz_i);
            width <= WID_W'(1);
            state <= ST_MEASURE;
          end else if (buzz_i != 3'd0) begin
            state <= ST_WAIT_LOW;
          end
        end
        ST_MEASURE: begin
          if (buzz_i == zone_pat) begin
            width <= width_inc;
            if (width_inc > WID_MAX) state <= ST_WAIT_LOW;
          end else if (buzz_i == 3'd0) begin
            state <= ST_IDLE;
          end else begin
            state <= ST_WAIT_LOW;
          end
        end
        ST_WAIT_LOW: begin
          if (buzz_i == 3'd0) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Counters follow the OK decision even when the FIFO drops the record.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int z = 0; z < 3; z++) cnt[z] <= '0;
      overflow <= 1'b0;
    end else if (ena) begin
      for (int z = 0; z < 3; z++) begin
        if (ok_push && push_rec.zone == zone_t'(z + 1) && cnt[z] != '1)
          cnt[z] <= cnt[z] + 1'b1;
      end
      if (push && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  alarm_evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .push      (push),
    .push_data (push_rec),
    .pop       (pop),
    .pop_data  (head_bits),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head        = evt_rec_t'(head_bits);
  assign evt_valid_o = !fifo_empty;
  assign evt_zone_o  = head.zone;
  assign evt_code_o  = head.code;
  assign overflow_o  = overflow;

  always_comb begin
    cnt_o = '0;
    if (cnt_sel_i != ZONE_NONE) cnt_o = cnt[cnt_sel_i - 2'd1];
  end

endmodule

`default_nettype wire
